uart_reg_arb: RTL and testbench

//  Round-robin arbiter sharing the single UART register port (access/addr/we/wdata/rdata)

---
 rtl/uart_reg_arb_if.sv | 34 +++
 rtl/uart_reg_arb.sv | 133 +++++++++++++
 tb/tb_uart_reg_arb.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_arb_if.sv
// Shared UART register-port bus: NUM_REQ requester lanes on one side, the single
// register access port on the other.
interface uart_reg_arb_if #(
    parameter int NUM_REQ = 2
);
    // req_valid_i[i] is held with its lock/we/addr/wdata slice until req_gnt_o[i];
    // the grant cycle is the capture. rsp_valid_o[i] is a 1-cycle pulse with no
    // back-pressure, and rsp_rdata_o is valid only alongside it.
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_lock_i;
    logic [NUM_REQ-1:0]    req_we_i;
    logic [NUM_REQ*12-1:0] req_addr_i;
    logic [NUM_REQ*16-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]    req_gnt_o;
    logic [NUM_REQ-1:0]    rsp_valid_o;
    logic [15:0]           rsp_rdata_o;
    logic                  reg_access_o;
    logic [11:0]           reg_addr_o;
    logic                  reg_we_o;
    logic [15:0]           reg_wdata_o;
    logic [15:0]           reg_rdata_i;

    modport slave (
        input  req_valid_i, req_lock_i, req_we_i, req_addr_i, req_wdata_i, reg_rdata_i,
        output req_gnt_o, rsp_valid_o, rsp_rdata_o, reg_access_o, reg_addr_o, reg_we_o,
               reg_wdata_o
    );

    modport master (
        output req_valid_i, req_lock_i, req_we_i, req_addr_i, req_wdata_i, reg_rdata_i,
        input  req_gnt_o, rsp_valid_o, rsp_rdata_o, reg_access_o, reg_addr_o, reg_we_o,
               reg_wdata_o
    );
endinterface

// File: rtl/uart_reg_arb.sv
// Round-robin arbiter with bounded lock bursts, sharing the UART register port
// between NUM_REQ requesters; one 1-cycle register access per grant.
module uart_reg_arb #(
    parameter int NUM_REQ  = 2,
    parameter int LOCK_MAX = 4
) (
    input  logic          pclk_i,
    input  logic          prst_ni,
    uart_reg_arb_if.slave bus,
    output logic          busy_o,
    output logic          dbg_state_o
);
    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = $clog2(LOCK_MAX) + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    state_e             state_q;
    logic [IDXW-1:0]    rr_q;
    logic [IDXW-1:0]    owner_q;
    logic [CNTW-1:0]    burst_q;
    logic               lock_q;
    logic               we_q;
    logic [11:0]        addr_q;
    logic [15:0]        wdata_q;
    logic [15:0]        rdata_q;
    logic [NUM_REQ-1:0] rsp_valid_q;

    logic               win_found;
    logic               lock_hit;
    logic [IDXW-1:0]    win_idx;
    logic [IDXW-1:0]    cand;
    logic               win_we;
    logic               win_lock;
    logic [11:0]        win_addr;
    logic [15:0]        win_wdata;
    logic [NUM_REQ-1:0] gnt;

    // Lock path keeps the last owner until the burst cap; otherwise scan from
    // rr_q+1 with wrap, so rr_q itself is considered last.
    always_comb begin
        win_found = 1'b0;
        lock_hit  = 1'b0;
        win_idx   = '0;
        cand      = '0;
        if (lock_q && bus.req_valid_i[rr_q] && (int'(burst_q) < LOCK_MAX - 1)) begin
            lock_hit  = 1'b1;
            win_found = 1'b1;
            win_idx   = rr_q;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = IDXW'((int'(rr_q) + k) % NUM_REQ);
                if (!win_found && bus.req_valid_i[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        win_we    = 1'b0;
        win_lock  = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDXW'(i)) begin
                win_we    = bus.req_we_i[i];
                win_lock  = bus.req_lock_i[i];
                win_addr  = bus.req_addr_i[12*i +: 12];
                win_wdata = bus.req_wdata_i[16*i +: 16];
            end
        end
    end

    // Gated by reset so every output reads 0 while prst_ni is low.
    always_comb begin
        gnt = '0;
        if (prst_ni && state_q == ST_IDLE && win_found) begin
            gnt[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) begin
            state_q     <= ST_IDLE;
            rr_q        <= IDXW'(NUM_REQ - 1);
            owner_q     <= '0;
            burst_q     <= '0;
            lock_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= '0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        state_q <= ST_ACCESS;
                        owner_q <= win_idx;
                        rr_q    <= win_idx;
                        lock_q  <= win_lock;
                        burst_q <= lock_hit ? burst_q + CNTW'(1) : '0;
                        we_q    <= win_we;
                        addr_q  <= win_addr & 12'hFFC;
                        wdata_q <= win_wdata;
                    end
                end
                ST_ACCESS: begin
                    state_q     <= ST_IDLE;
                    rdata_q     <= we_q ? 16'h0000 : bus.reg_rdata_i;
                    rsp_valid_q <= NUM_REQ'(1) << owner_q;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_gnt_o    = gnt;
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_rdata_o  = rdata_q;
    assign bus.reg_access_o = (state_q == ST_ACCESS);
    assign bus.reg_we_o     = (state_q == ST_ACCESS) && we_q;
    assign bus.reg_addr_o   = addr_q;
    assign bus.reg_wdata_o  = wdata_q;
    assign busy_o           = (state_q == ST_ACCESS);
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_uart_reg_arb.sv
// Bench for uart_reg_arb: a 2-requester and a 3-requester instance, directed
// requester tables, grant-order checks and a decoupled access/response scoreboard.
module tb_uart_reg_arb;
    logic pclk_i  = 1'b0;
    logic prst_ni = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 pclk_i = ~pclk_i;
    always @(posedge pclk_i) cyc <= cyc + 1;

    uart_reg_arb_if #(.NUM_REQ(2)) if2 ();
    uart_reg_arb_if #(.NUM_REQ(3)) if3 ();
    logic busy2, busy3, st2, st3;

    uart_reg_arb #(.NUM_REQ(2), .LOCK_MAX(4)) dut2 (
        .pclk_i(pclk_i), .prst_ni(prst_ni), .bus(if2.slave), .busy_o(busy2), .dbg_state_o(st2)
    );
    uart_reg_arb #(.NUM_REQ(3), .LOCK_MAX(4)) dut3 (
        .pclk_i(pclk_i), .prst_ni(prst_ni), .bus(if3.slave), .busy_o(busy3), .dbg_state_o(st3)
    );

    // Register file model: read data = 0x00A1 + word address.
    assign if2.reg_rdata_i = 16'h00A1 + {4'h0, if2.reg_addr_o};
    assign if3.reg_rdata_i = 16'h00A1 + {4'h0, if3.reg_addr_o};

    logic [2:0]  r_we, r_lock;
    logic [11:0] r_addr[3], r_exp_addr[3];
    logic [15:0] r_wdata[3], r_exp_rdata[3];

    logic [1:0]  exp_gnt_q[$];
    logic [45:0] exp_acc_q[$];  // {cycle16, dut, addr12, we, wdata16}
    logic [34:0] exp_rsp_q[$];  // {cycle16, dut, owner2, rdata16}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @cyc %0d", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [11:0] addr,
                           input logic [15:0] wdata, input logic [11:0] exp_addr,
                           input logic [15:0] exp_rdata, input logic lock);
        r_we[i] = we; r_addr[i] = addr; r_wdata[i] = wdata;
        r_exp_addr[i] = exp_addr; r_exp_rdata[i] = exp_rdata; r_lock[i] = lock;
    endtask

    task automatic apply(input int d, input logic [2:0] valid);
        if (d == 0) begin
            if2.req_valid_i = valid[1:0];
            if2.req_lock_i  = r_lock[1:0];
            if2.req_we_i    = r_we[1:0];
            if2.req_addr_i  = {r_addr[1], r_addr[0]};
            if2.req_wdata_i = {r_wdata[1], r_wdata[0]};
        end else begin
            if3.req_valid_i = valid;
            if3.req_lock_i  = r_lock;
            if3.req_we_i    = r_we;
            if3.req_addr_i  = {r_addr[2], r_addr[1], r_addr[0]};
            if3.req_wdata_i = {r_wdata[2], r_wdata[1], r_wdata[0]};
        end
    endtask

    function automatic logic [2:0] get_gnt(input int d);
        return (d == 0) ? {1'b0, if2.req_gnt_o} : if3.req_gnt_o;
    endfunction

    // Requester i keeps asking until it has been granted n[i] times.
    task automatic drive(input int d, input int n0, input int n1, input int n2);
        int rem[3];
        int prev;
        int budget;
        int w;
        int ones;
        logic [2:0] g;
        rem = '{n0, n1, n2};
        prev = -1;
        budget = 0;
        while ((rem[0] + rem[1] + rem[2]) > 0 && budget < 200) begin
            @(negedge pclk_i);
            apply(d, {rem[2] > 0, rem[1] > 0, rem[0] > 0});
            #1;
            g = get_gnt(d);
            if (g != 3'b000) begin
                w = 0; ones = 0;
                for (int i = 0; i < 3; i++) if (g[i]) begin w = i; ones++; end
                chk("gnt_onehot", ones, 1);
                if (exp_gnt_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL gnt_extra actual=%0d required=none", w);
                end else begin
                    chk("gnt_order", w, 32'(exp_gnt_q.pop_front()));
                end
                if (prev >= 0) chk("gnt_gap", cyc - prev, 2);
                prev = cyc;
                exp_acc_q.push_back({16'(cyc + 1), d[0], r_exp_addr[w], r_we[w], r_wdata[w]});
                exp_rsp_q.push_back({16'(cyc + 2), d[0], 2'(w), r_exp_rdata[w]});
                if (rem[w] > 0) rem[w]--;
            end
            budget++;
        end
        if (budget >= 200) begin
            checks++; errors++;
            $display("FAIL drive_timeout actual=%0d required=<200 cycles", budget);
        end
        @(negedge pclk_i);
        apply(d, 3'b000);
        repeat (3) @(negedge pclk_i);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl2"}, {if2.req_gnt_o, if2.rsp_valid_o, if2.reg_access_o, if2.reg_we_o, busy2}, 0);
        chk({name, "_dat2"}, {if2.reg_addr_o, if2.rsp_rdata_o}, 0);
        chk({name, "_wd2"}, if2.reg_wdata_o, 0);
        chk({name, "_ctl3"}, {if3.req_gnt_o, if3.rsp_valid_o, if3.reg_access_o, if3.reg_we_o, busy3}, 0);
        chk({name, "_dat3"}, {if3.reg_addr_o, if3.rsp_rdata_o, if3.reg_wdata_o}, 0);
    endtask

    task automatic do_reset();
        @(negedge pclk_i);
        prst_ni = 1'b0;
        repeat (2) @(negedge pclk_i);
        prst_ni = 1'b1;
    endtask

    // Scoreboard monitor: compares every register access and response pulse.
    always @(negedge pclk_i) begin : mon
        logic acc, we, bsy;
        logic [11:0] a;
        logic [15:0] wd, rd;
        logic [2:0] rv;
        logic [45:0] e;
        logic [34:0] r;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                acc = if2.reg_access_o; we = if2.reg_we_o; bsy = busy2; a = if2.reg_addr_o;
                wd = if2.reg_wdata_o; rd = if2.rsp_rdata_o; rv = {1'b0, if2.rsp_valid_o};
            end else begin
                acc = if3.reg_access_o; we = if3.reg_we_o; bsy = busy3; a = if3.reg_addr_o;
                wd = if3.reg_wdata_o; rd = if3.rsp_rdata_o; rv = if3.rsp_valid_o;
            end
            if (acc) begin
                if (exp_acc_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL acc_extra actual=dut%0d addr %h required=none", d, a);
                end else begin
                    e = exp_acc_q.pop_front();
                    chk("acc_cycle", 32'(cyc[15:0]), 32'(e[45:30]));
                    chk("acc_dut", d, 32'(e[29]));
                    chk("acc_addr", a, e[28:17]);
                    chk("acc_we", we, e[16]);
                    if (e[16]) chk("acc_wdata", wd, e[15:0]);
                    chk("acc_busy", bsy, 1);
                end
            end else begin
                chk("idle_we", we, 0);
                chk("idle_busy", bsy, 0);
            end
            if (rv != 3'b000) begin
                if (exp_rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_extra actual=dut%0d valid %b required=none", d, rv);
                end else begin
                    r = exp_rsp_q.pop_front();
                    chk("rsp_cycle", 32'(cyc[15:0]), 32'(r[34:19]));
                    chk("rsp_dut", d, 32'(r[18]));
                    chk("rsp_valid", rv, 32'(3'b001 << r[17:16]));
                    chk("rsp_rdata", rd, r[15:0]);
                end
            end
        end
    end

    initial begin
        r_we = '0; r_lock = '0;
        for (int i = 0; i < 3; i++) begin
            r_addr[i] = '0; r_wdata[i] = '0; r_exp_addr[i] = '0; r_exp_rdata[i] = '0;
        end
        apply(0, 3'b000);
        apply(1, 3'b000);
        repeat (3) @(negedge pclk_i);
        chk_zero("reset");
        prst_ni = 1'b1;

        // Single read from requester 0.
        set_req(0, 1'b0, 12'h004, 16'h0000, 12'h004, 16'h00A5, 1'b0);
        exp_gnt_q = '{0};
        drive(0, 1, 0, 0);

        // Plain round robin, both requesting.
        do_reset();
        set_req(0, 1'b0, 12'h010, 16'h0000, 12'h010, 16'h00B1, 1'b0);
        set_req(1, 1'b0, 12'h021, 16'h0000, 12'h020, 16'h00C1, 1'b0);
        exp_gnt_q = '{0, 1, 0, 1, 0, 1, 0, 1};
        drive(0, 4, 4, 0);

        // Write with an unaligned address.
        set_req(1, 1'b1, 12'h00E, 16'h1234, 12'h00C, 16'h0000, 1'b0);
        exp_gnt_q = '{1};
        drive(0, 0, 1, 0);

        // Locked requester 0 against pending requester 1: cap forces rotation.
        do_reset();
        set_req(0, 1'b0, 12'h008, 16'h0000, 12'h008, 16'h00A9, 1'b1);
        set_req(1, 1'b1, 12'h030, 16'hBEEF, 12'h030, 16'h0000, 1'b0);
        exp_gnt_q = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        drive(0, 9, 2, 0);

        // Locked requester alone past the cap, then a competitor shows the restarted burst.
        exp_gnt_q = '{0, 0, 0, 0, 0};
        drive(0, 5, 0, 0);
        exp_gnt_q = '{0, 0, 1};
        drive(0, 2, 1, 0);

        // Reset during ACCESS drops the response; next grant goes to requester 0.
        do_reset();
        set_req(0, 1'b0, 12'h004, 16'h0000, 12'h004, 16'h00A5, 1'b0);
        @(negedge pclk_i);
        apply(0, 3'b001);
        #1;
        chk("mid_gnt", get_gnt(0), 3'b001);
        exp_acc_q.push_back({16'(cyc + 1), 1'b0, 12'h004, 1'b0, 16'h0000});
        @(negedge pclk_i);
        apply(0, 3'b000);
        #2;
        prst_ni = 1'b0;
        #1;
        chk_zero("mid_reset");
        repeat (2) @(negedge pclk_i);
        #2;
        prst_ni = 1'b1;
        exp_gnt_q = '{0, 1};
        drive(0, 1, 1, 0);

        // Three requesters: wrap-around from rr_last = 2.
        set_req(0, 1'b0, 12'h100, 16'h0000, 12'h100, 16'h01A1, 1'b0);
        set_req(1, 1'b0, 12'h204, 16'h0000, 12'h204, 16'h02A5, 1'b0);
        set_req(2, 1'b1, 12'h3FF, 16'h5A5A, 12'h3FC, 16'h0000, 1'b0);
        exp_gnt_q = '{2};
        drive(1, 0, 0, 1);
        exp_gnt_q = '{0, 1, 2};
        drive(1, 1, 1, 1);

        repeat (4) @(negedge pclk_i);
        chk("gnt_left", exp_gnt_q.size(), 0);
        chk("acc_left", exp_acc_q.size(), 0);
        chk("rsp_left", exp_rsp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
